hsi_obi_cfg_master: RTL and testbench
=====================================

Name: hsi_obi_cfg_master

Overview:
- OBI initiator that programs and runs one HSI vector-core operation per command by driving the core's OBI configuration responder.
- Sits between a local command source (DMA sequencer or test controller) and the responder's 32-bit OBI slave port.
- Per command it writes OP_CODE, writes NUM_BANDS, writes START, then polls STATUS until the done bit is set.
- It then returns the core error code and a bus-error flag.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the responder register block.
- OP_CODE_WIDTH, 8, op-code width.
- NUM_BANDS_WIDTH, 8, band-count width.
- ERR_WIDTH, 8, core error-code width (STATUS bits [ERR_WIDTH:1]).
- TIMEOUT_CYCLES, 4096, poll timeout limit (used only with the optional feature).

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- cmd_valid_i  input  1  command valid
- cmd_ready_o  output  1  block idle and accepting a command
- cmd_op_code_i  input  OP_CODE_WIDTH  op code for this command
- cmd_num_bands_i  input  NUM_BANDS_WIDTH  band count for this command
- rsp_valid_o  output  1  one-cycle pulse: command finished
- rsp_bus_err_o  output  1  an OBI err_i was seen (valid with rsp_valid_o)
- rsp_timeout_o  output  1  poll timeout occurred (valid with rsp_valid_o)
- rsp_error_code_o  output  ERR_WIDTH  core error code from STATUS
- busy_o  output  1  command in progress
- req_o  output  1  OBI request
- we_o  output  1  OBI write enable
- be_o  output  4  OBI byte enables, always 4'hF
- addr_o  output  32  OBI address
- wdata_o  output  32  OBI write data
- gnt_i  input  1  OBI grant
- rvalid_i  input  1  OBI response valid
- rdata_i  input  32  OBI read data
- err_i  input  1  OBI response error

Behaviour:
- Reset: all outputs 0 except cmd_ready_o=1 and be_o=4'hF. FSM is IDLE; all counters are 0. Reset mid-transaction abandons the transfer immediately; no response is generated.
- Handshake, command side: a command is accepted when cmd_valid_i && cmd_ready_o. op_code and num_bands are latched at acceptance. cmd_ready_o=1 only in IDLE.
- OBI rules:
  - At most one outstanding transfer.
  - req_o, we_o, addr_o and wdata_o are registered and held stable from req assertion until the cycle gnt_i=1. req_o drops the cycle after grant.
  - gnt_i in the same cycle req_o first rises is legal and counts.
  - After grant, the FSM waits for rvalid_i. rdata_i and err_i are sampled only when rvalid_i=1.
  - rvalid_i while no transfer is outstanding is ignored.
- FSM states: IDLE, ADDR, RESP, DONE. A step register selects the current access:
  - S_OP: write BASE+0x00, data = zero-extended op_code.
  - S_NB: write BASE+0x04, data = zero-extended num_bands.
  - S_START: write BASE+0x08, data = 32'h1.
  - S_POLL: read BASE+0x0C.
- Transitions:
  - IDLE -> ADDR on accept, step=S_OP.
  - ADDR -> RESP on gnt_i.
  - RESP on rvalid_i:
    - If err_i=1: set bus_err, go to DONE.
    - Else for S_OP, S_NB, S_START: advance step, go to ADDR.
    - Else for S_POLL with rdata_i[0]=1: capture rdata_i[ERR_WIDTH:1] into rsp_error_code_o, go to DONE.
    - Else for S_POLL with rdata_i[0]=0: reissue the poll (ADDR), with no idle cycles required.
  - DONE: rsp_valid_o=1 for exactly one cycle, then IDLE.
- Response fields:
  - rsp_bus_err_o, rsp_timeout_o and rsp_error_code_o hold their values until the next accept.
  - They are cleared on accept.
  - rsp_error_code_o=0 when rsp_bus_err_o=1.
- busy_o = !cmd_ready_o.
- Minimum command latency with a zero-wait responder (grant same cycle, rvalid next cycle), done on the first poll: 4 accesses × 2 cycles + 1 DONE cycle = 9 cycles from accept to rsp_valid_o.

Optional Feature:
- Macro: HSI_OBI_MASTER_TIMEOUT_EN.
- With the macro:
  - A 32-bit counter clears on entry to S_POLL and increments every cycle spent in S_POLL ADDR/RESP.
  - When it reaches TIMEOUT_CYCLES while in ADDR (no transfer outstanding), the FSM goes to DONE with rsp_timeout_o=1 and rsp_error_code_o=0.
  - When it reaches TIMEOUT_CYCLES while in RESP, the FSM finishes the outstanding transfer, then goes to DONE with the timeout flag set. A done bit read in that same response takes priority; the timeout flag is not set.
- Without the macro: no counter, rsp_timeout_o tied to 0, polling is unbounded.

Test Plan:
- Zero-wait responder, op=0x03, bands=0x10, done on first poll -> writes seen at 0x00=0x3, 0x04=0x10, 0x08=0x1, then read 0x0C; rsp_valid_o 9 cycles after accept; error_code=0.
- Responder with grant one cycle late and rvalid one cycle after grant; STATUS=0x0 twice then 0x0000_000B -> 3 polls, rsp_error_code_o=0x05, addr_o/wdata_o stable while ungranted.
- err_i=1 on the NUM_BANDS write -> no START or poll issued; rsp_bus_err_o=1, rsp_error_code_o=0; cmd_ready_o=1 the cycle after rsp_valid_o.
- cmd_valid_i held high through a command -> second command accepted only after rsp_valid_o; no acceptance while busy_o=1; spurious rvalid_i in IDLE ignored.
- Reset asserted mid-poll -> all outputs at reset values immediately; next command runs normally from S_OP.
- HSI_OBI_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=32, STATUS always 0 -> rsp_timeout_o=1 and rsp_valid_o within 32+2 cycles of the first poll; with the macro undefined, polling continues indefinitely.

Source files
------------

// File: rtl/hsi_obi_cfg_master.sv
// OBI initiator: per command writes OP_CODE, NUM_BANDS, START, then polls STATUS until done.
// Optional poll timeout enabled by defining HSI_OBI_MASTER_TIMEOUT_EN.
module hsi_obi_cfg_master #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned OP_CODE_WIDTH   = 8,
  parameter int unsigned NUM_BANDS_WIDTH = 8,
  parameter int unsigned ERR_WIDTH       = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [OP_CODE_WIDTH-1:0]   cmd_op_code_i,
  input  logic [NUM_BANDS_WIDTH-1:0] cmd_num_bands_i,
  output logic                       rsp_valid_o,
  output logic                       rsp_bus_err_o,
  output logic                       rsp_timeout_o,
  output logic [ERR_WIDTH-1:0]       rsp_error_code_o,
  output logic                       busy_o,
  output logic                       req_o,
  output logic                       we_o,
  output logic [3:0]                 be_o,
  output logic [31:0]                addr_o,
  output logic [31:0]                wdata_o,
  input  logic                       gnt_i,
  input  logic                       rvalid_i,
  input  logic [31:0]                rdata_i,
  input  logic                       err_i
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ADDR = 2'd1, ST_RESP = 2'd2, ST_DONE = 2'd3} state_e;
  typedef enum logic [1:0] {S_OP = 2'd0, S_NB = 2'd1, S_START = 2'd2, S_POLL = 2'd3} step_e;

  state_e                     r_state, w_state_nxt;
  step_e                      r_step, w_step_nxt;
  logic [NUM_BANDS_WIDTH-1:0] r_nb;
  logic                       r_req, r_we;
  logic [31:0]                r_addr, r_wdata;
  logic                       r_bus_err, r_timeout;
  logic [ERR_WIDTH-1:0]       r_err_code;
  logic                       w_accept, w_set_bus_err, w_set_code, w_set_timeout;
  logic                       w_to_hit, w_load_addr, w_we_nxt;
  logic [31:0]                w_addr_nxt, w_wdata_nxt;

  function automatic step_e step_after(input step_e s);
    case (s)
      S_OP:    step_after = S_NB;
      S_NB:    step_after = S_START;
      S_START: step_after = S_POLL;
      default: step_after = S_POLL;
    endcase
  endfunction

  assign w_accept = cmd_valid_i && (r_state == ST_IDLE);

  // next-state and response-event decode
  always_comb begin
    w_state_nxt   = r_state;
    w_step_nxt    = r_step;
    w_set_bus_err = 1'b0;
    w_set_code    = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          w_state_nxt = ST_ADDR;
          w_step_nxt  = S_OP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ADDR: begin
        // a grant in the same cycle as the timeout wins; the transfer is then finished
        if (gnt_i) begin
          w_state_nxt = ST_RESP;
        end else if (w_to_hit) begin
          w_state_nxt   = ST_DONE;
          w_set_timeout = 1'b1;
        end else begin
          w_state_nxt = ST_ADDR;
        end
      end
      ST_RESP: begin
        if (!rvalid_i) begin
          w_state_nxt = ST_RESP;
        end else if (err_i) begin
          w_state_nxt   = ST_DONE;
          w_set_bus_err = 1'b1;
        end else if (r_step != S_POLL) begin
          w_state_nxt = ST_ADDR;
          w_step_nxt  = step_after(r_step);
        end else if (rdata_i[0]) begin
          w_state_nxt = ST_DONE;
          w_set_code  = 1'b1;
        end else if (w_to_hit) begin
          w_state_nxt   = ST_DONE;
          w_set_timeout = 1'b1;
        end else begin
          w_state_nxt = ST_ADDR;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // address/data of the access about to be issued
  always_comb begin
    w_we_nxt    = 1'b1;
    w_addr_nxt  = BASE_ADDR;
    w_wdata_nxt = 32'h0000_0000;
    case (w_step_nxt)
      S_OP: begin
        w_addr_nxt  = BASE_ADDR + 32'h0000_0000;
        w_wdata_nxt = 32'(cmd_op_code_i);
      end
      S_NB: begin
        w_addr_nxt  = BASE_ADDR + 32'h0000_0004;
        w_wdata_nxt = 32'(r_nb);
      end
      S_START: begin
        w_addr_nxt  = BASE_ADDR + 32'h0000_0008;
        w_wdata_nxt = 32'h0000_0001;
      end
      S_POLL: begin
        w_we_nxt    = 1'b0;
        w_addr_nxt  = BASE_ADDR + 32'h0000_000C;
        w_wdata_nxt = 32'h0000_0000;
      end
      default: begin
        w_we_nxt    = 1'b1;
        w_addr_nxt  = BASE_ADDR;
        w_wdata_nxt = 32'h0000_0000;
      end
    endcase
  end

  assign w_load_addr = (w_state_nxt == ST_ADDR) && (r_state != ST_ADDR);

  // FSM state and step registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_step  <= S_OP;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  // OBI request registers and latched band count; request fields only change on ADDR entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'h0000_0000;
      r_wdata <= 32'h0000_0000;
      r_nb    <= '0;
    end else begin
      r_req <= (w_state_nxt == ST_ADDR);
      if (w_load_addr) begin
        r_we    <= w_we_nxt;
        r_addr  <= w_addr_nxt;
        r_wdata <= w_wdata_nxt;
      end
      if (w_accept) begin
        r_nb <= cmd_num_bands_i;
      end
    end
  end

  // response fields: cleared on accept, held until the next accept
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bus_err  <= 1'b0;
      r_timeout  <= 1'b0;
      r_err_code <= '0;
    end else if (w_accept) begin
      r_bus_err  <= 1'b0;
      r_timeout  <= 1'b0;
      r_err_code <= '0;
    end else if (w_set_bus_err) begin
      r_bus_err  <= 1'b1;
      r_err_code <= '0;
    end else if (w_set_code) begin
      r_err_code <= rdata_i[ERR_WIDTH:1];
    end else if (w_set_timeout) begin
      r_timeout  <= 1'b1;
      r_err_code <= '0;
    end
  end

`ifdef HSI_OBI_MASTER_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        w_unused;

  assign w_to_hit      = (r_step == S_POLL) && (r_to_cnt >= 32'(TIMEOUT_CYCLES));
  assign rsp_timeout_o = r_timeout;
  assign w_unused      = ^{rdata_i[31:ERR_WIDTH+1]};

  // poll-phase cycle counter, saturating at the limit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_to_cnt <= 32'h0000_0000;
    end else if ((w_step_nxt == S_POLL) && (r_step != S_POLL)) begin
      r_to_cnt <= 32'h0000_0000;
    end else if ((r_step == S_POLL) && ((r_state == ST_ADDR) || (r_state == ST_RESP)) && !w_to_hit) begin
      r_to_cnt <= r_to_cnt + 32'h0000_0001;
    end
  end
`else
  logic w_unused;

  assign w_to_hit      = 1'b0;
  assign rsp_timeout_o = 1'b0;
  assign w_unused      = ^{rdata_i[31:ERR_WIDTH+1], r_timeout, 32'(TIMEOUT_CYCLES)};
`endif

  assign cmd_ready_o      = (r_state == ST_IDLE);
  assign busy_o           = (r_state != ST_IDLE);
  assign rsp_valid_o      = (r_state == ST_DONE);
  assign rsp_bus_err_o    = r_bus_err;
  assign rsp_error_code_o = r_err_code;
  assign req_o            = r_req;
  assign we_o             = r_we;
  assign be_o             = 4'hF;
  assign addr_o           = r_addr;
  assign wdata_o          = r_wdata;

endmodule

// File: tb/tb_hsi_obi_cfg_master.sv
// Self-checking bench for hsi_obi_cfg_master: randomized OBI responder timing and STATUS
// sequences checked against an access-list / latency model of the command protocol.
module tb_hsi_obi_cfg_master;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [7:0]  cmd_op_code_i = 8'h00;
  logic [7:0]  cmd_num_bands_i = 8'h00;
  logic        rsp_valid_o, rsp_bus_err_o, rsp_timeout_o;
  logic [7:0]  rsp_error_code_o;
  logic        busy_o, req_o, we_o;
  logic [3:0]  be_o;
  logic [31:0] addr_o, wdata_o;
  logic        gnt_i = 1'b0;
  logic        rvalid_i = 1'b0;
  logic [31:0] rdata_i = 32'h0;
  logic        err_i = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  always #5 clk_i = ~clk_i;

  hsi_obi_cfg_master #(.TIMEOUT_CYCLES(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_code_i(cmd_op_code_i), .cmd_num_bands_i(cmd_num_bands_i),
    .rsp_valid_o(rsp_valid_o), .rsp_bus_err_o(rsp_bus_err_o),
    .rsp_timeout_o(rsp_timeout_o), .rsp_error_code_o(rsp_error_code_o),
    .busy_o(busy_o), .req_o(req_o), .we_o(we_o), .be_o(be_o),
    .addr_o(addr_o), .wdata_o(wdata_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_i(err_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_ready"}, 32'(cmd_ready_o), 32'd1);
    chk({tag, "_be"}, 32'(be_o), 32'hF);
    chk({tag, "_zero_outs"},
        32'({req_o, we_o, rsp_valid_o, rsp_bus_err_o, rsp_timeout_o, busy_o}), 32'd0);
    chk({tag, "_addr"}, addr_o, 32'd0);
    chk({tag, "_wdata"}, wdata_o, 32'd0);
    chk({tag, "_code"}, 32'(rsp_error_code_o), 32'd0);
  endtask

  // One command: drives the command, plays the OBI responder, checks against the model.
  // Called at a negedge; returns at a negedge (or right after an abort reset).
  task automatic run_cmd(input logic [7:0] op, input logic [7:0] nb, input int gd, input int rd,
                         input int nwait, input logic [7:0] code, input int err_idx,
                         input bit hold, input int abort_at, input bit exp_to);
    txn_t exp_q[$];
    txn_t obs_q[$];
    txn_t cap, cur;
    int n_acc, exp_lat, cyc, done_cyc, req_age, rv_left, first_poll, limit, idx;
    bit outstanding, flags_bad, aborted, match;
    logic [31:0] d;
    logic [7:0] exp_code;

    n_acc = 4 + nwait;
    if (err_idx >= 0 && err_idx + 1 < n_acc) n_acc = err_idx + 1;
    for (int i = 0; i < n_acc; i++) begin
      cur.we = (i < 3);
      cur.addr = (i < 3) ? 32'(4 * i) : 32'h0000_000C;
      cur.wdata = (i == 0) ? {24'h0, op} : (i == 1) ? {24'h0, nb} : (i == 2) ? 32'h1 : 32'h0;
      exp_q.push_back(cur);
    end
    exp_lat = n_acc * (gd + 1 + rd) + 1;
    limit = exp_to ? 300 : exp_lat + 20;
    if (abort_at > 0) limit = abort_at + 5;

    cmd_valid_i = 1'b1;
    cmd_op_code_i = op;
    cmd_num_bands_i = nb;
    chk("ready_before_accept", 32'(cmd_ready_o), 32'd1);
    @(posedge clk_i);

    cyc = 0; done_cyc = 0; req_age = 0; rv_left = 0; first_poll = -1;
    outstanding = 1'b0; flags_bad = 1'b0; aborted = 1'b0;
    cap = '0;
    while (1) begin
      @(negedge clk_i);
      cyc++;
      if (!hold) begin
        cmd_valid_i = 1'b0;
        cmd_op_code_i = 8'($urandom);
        cmd_num_bands_i = 8'($urandom);
      end
      gnt_i = 1'b0; rvalid_i = 1'b0; err_i = 1'b0; rdata_i = $urandom;
      if (cyc == abort_at) begin
        rst_ni = 1'b0;
        #1;
        reset_check("abort_reset");
        aborted = 1'b1;
        break;
      end
      if (rsp_valid_o) begin
        done_cyc = cyc;
        break;
      end
      if (cmd_ready_o !== 1'b0 || busy_o !== 1'b1 || be_o !== 4'hF) flags_bad = 1'b1;
      if (outstanding) begin
        if (req_o) flags_bad = 1'b1;
        rv_left--;
        if (rv_left == 0) begin
          idx = obs_q.size() - 1;
          rvalid_i = 1'b1;
          outstanding = 1'b0;
          if (idx == err_idx) begin
            err_i = 1'b1;
          end else if (idx >= 3) begin
            if (idx - 3 < nwait) begin
              rdata_i = $urandom & 32'hFFFF_FFFE;
            end else begin
              d = $urandom;
              d[8:1] = code;
              d[0] = 1'b1;
              rdata_i = d;
            end
          end
        end
      end else if (req_o) begin
        if (req_age == 0) cap = {we_o, addr_o, wdata_o};
        else if ({we_o, addr_o, wdata_o} !== cap) flags_bad = 1'b1;
        if (req_age == gd) begin
          gnt_i = 1'b1;
          obs_q.push_back(cap);
          if (first_poll < 0 && cap.addr == 32'h0000_000C) first_poll = cyc - gd;
          outstanding = 1'b1;
          rv_left = rd;
          req_age = 0;
        end else begin
          req_age++;
        end
      end
      if (cyc > limit) break;
    end
    gnt_i = 1'b0; rvalid_i = 1'b0; err_i = 1'b0;

    if (abort_at > 0) begin
      chk("abort_reached_without_rsp", 32'(aborted), 32'd1);
    end else begin
      chk("rsp_valid_seen", 32'(done_cyc > 0), 32'd1);
      chk("protocol_flags", 32'(flags_bad), 32'd0);
      if (exp_to) begin
        chk("timeout_bound", 32'((first_poll >= 0) && (done_cyc - first_poll <= 34)), 32'd1);
      end else begin
        chk("latency", 32'(done_cyc), 32'(exp_lat));
        chk("num_accesses", 32'(obs_q.size()), 32'(exp_q.size()));
        match = (obs_q.size() == exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
          if (obs_q[i].we !== exp_q[i].we || obs_q[i].addr !== exp_q[i].addr) match = 1'b0;
          if (exp_q[i].we && obs_q[i].wdata !== exp_q[i].wdata) match = 1'b0;
        end
        chk("access_list", 32'(match), 32'd1);
      end
      exp_code = (err_idx >= 0 && err_idx < 4 + nwait) || exp_to ? 8'h00 : code;
      chk("rsp_bus_err", 32'(rsp_bus_err_o), 32'((err_idx >= 0) && (err_idx < 4 + nwait)));
      chk("rsp_timeout", 32'(rsp_timeout_o), 32'(exp_to));
      chk("rsp_error_code", 32'(rsp_error_code_o), 32'(exp_code));
      @(negedge clk_i);
      chk("ready_after_rsp", 32'({cmd_ready_o, busy_o, rsp_valid_o}), 32'b100);
      chk("code_held", 32'(rsp_error_code_o), 32'(exp_code));
    end
  endtask

  initial begin
    int gd, rd, nw, e;
    repeat (3) @(negedge clk_i);
    reset_check("reset");
    rst_ni = 1'b1;

    // zero-wait responder, done on first poll
    run_cmd(8'h03, 8'h10, 0, 1, 0, 8'h00, -1, 1'b0, 0, 1'b0);
    // late grant, two busy polls then STATUS code 5
    run_cmd(8'($urandom), 8'($urandom), 1, 1, 2, 8'h05, -1, 1'b0, 0, 1'b0);
    // bus error on the NUM_BANDS write
    run_cmd(8'h21, 8'h07, 0, 1, 0, 8'h33, 1, 1'b0, 0, 1'b0);

    // stray responses in IDLE must be ignored
    for (int i = 0; i < 3; i++) begin
      rvalid_i = 1'b1; err_i = 1'b1; rdata_i = 32'hFFFF_FFFF;
      @(negedge clk_i);
      chk("idle_stray_rvalid", 32'({cmd_ready_o, busy_o, rsp_valid_o, req_o}), 32'b1000);
    end
    rvalid_i = 1'b0; err_i = 1'b0;
    chk("idle_fields_held", 32'(rsp_bus_err_o), 32'd1);

    // valid held high across back-to-back commands
    run_cmd(8'h5A, 8'h01, 0, 1, 1, 8'h7E, -1, 1'b1, 0, 1'b0);
    run_cmd(8'hA5, 8'hFF, 0, 2, 0, 8'h81, -1, 1'b1, 0, 1'b0);
    run_cmd(8'h11, 8'h22, 2, 1, 0, 8'hFF, -1, 1'b0, 0, 1'b0);

    // randomized responder timing, poll counts and error injection
    for (int k = 0; k < 8; k++) begin
      gd = int'($urandom_range(0, 2));
      rd = int'($urandom_range(1, 3));
      nw = int'($urandom_range(0, 3));
      e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3 + nw)) : -1;
      run_cmd(8'($urandom), 8'($urandom), gd, rd, nw, 8'($urandom), e, 1'b0, 0, 1'b0);
    end

    // reset in the middle of polling, then a normal command
    run_cmd(8'h44, 8'h08, 0, 1, 5, 8'h09, -1, 1'b0, 10, 1'b0);
    @(negedge clk_i);
    reset_check("held_reset");
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("no_rsp_after_reset", 32'(rsp_valid_o), 32'd0);
    run_cmd(8'h0F, 8'h0E, 0, 1, 0, 8'h12, -1, 1'b0, 0, 1'b0);

`ifdef HSI_OBI_MASTER_TIMEOUT_EN
    run_cmd(8'h01, 8'h02, 0, 1, 1000, 8'h00, -1, 1'b0, 0, 1'b1);
`else
    // without the timeout, polling never ends on its own
    run_cmd(8'h01, 8'h02, 0, 1, 400, 8'h00, -1, 1'b0, 300, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
